// File: rtl/wasm_operand_stack_pkg.sv
// wasm_operand_stack_pkg: op encodings, type tags, trap codes and FSM states shared with the cpu core
package wasm_operand_stack_pkg;
    typedef enum logic [2:0] {
        OP_NOP, OP_PUSH, OP_POP, OP_GET_LOCAL, OP_SET_LOCAL, OP_TEE_LOCAL, OP_SET_FRAME, OP_DROP_TO
    } op_e;
    typedef enum logic [1:0] {T_I32, T_I64, T_F32, T_F64} type_e;
    // Must stay aligned with the cpu trap enumeration.
    typedef enum logic [3:0] {
        TRAP_NONE, TRAP_STACK_OVERFLOW, TRAP_STACK_UNDERFLOW, TRAP_LOCAL_RANGE, TRAP_TYPE_MISMATCH, TRAP_NO_64B
    } trap_e;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HALT} state_e;
endpackage

// File: rtl/wasm_operand_stack_if.sv
// wasm_operand_stack_if: decode-stage op request bus and stack status outputs
interface wasm_operand_stack_if #(
    parameter int DW = 64,
    parameter int PW = 8
);
    logic [2:0] op;
    logic op_valid;
    logic op_ready;
    logic [DW-1:0] data_in;
    logic [1:0] type_in;
    logic [PW-1:0] index;
    logic [DW-1:0] top;
    logic [1:0] top_type;
    logic empty;
    logic [PW-1:0] depth;
    logic [3:0] trap;
    modport master (
        output op, op_valid, data_in, type_in, index,
        input op_ready, top, top_type, empty, depth, trap
    );
    modport slave (
        input op, op_valid, data_in, type_in, index,
        output op_ready, top, top_type, empty, depth, trap
    );
endinterface

// File: rtl/wasm_operand_stack_stack_ram.sv
// wasm_operand_stack_stack_ram: 1R1W register array, combinational read, synchronous write
module wasm_operand_stack_stack_ram #(
    parameter int W = 66,
    parameter int AW = 7
) (
    input logic clk,
    input logic we,
    input logic [AW-1:0] waddr,
    input logic [W-1:0] wdata,
    input logic [AW-1:0] raddr,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/wasm_operand_stack.sv
// wasm_operand_stack: typed operand stack with frame-relative locals and sticky traps
module wasm_operand_stack
    import wasm_operand_stack_pkg::*;
#(
    parameter int USE_64B = 1,
    parameter int STACK_DEPTH = 7
) (
    input logic clk,
    input logic reset,
    wasm_operand_stack_if.slave bus
);
    localparam int DW = USE_64B != 0 ? 64 : 32;
    localparam int AW = STACK_DEPTH;
    localparam int PW = STACK_DEPTH + 1;
    localparam logic [PW-1:0] FULL = {1'b1, {AW{1'b0}}};
    state_e state, state_t, state_n;
    logic [PW-1:0] sp, fp, sp_t, fp_t, sp_n, fp_n;
    logic [3:0] trap, code;
    logic [DW-1:0] top_q, acc_data;
    logic [1:0] tt_q, acc_tag;
    logic [2:0] acc_op;
    logic [AW-1:0] acc_addr, waddr, raddr, spm1;
    logic [DW+1:0] wdata, rdata;
    logic [PW:0] sum;
    logic we_t, rd_local, go, halt, fwd, local_bad;
    // One extra bit on the frame sum so a carry reads as out of range.
    assign sum = {1'b0, fp} + {1'b0, bus.index};
    assign local_bad = sum >= {1'b0, sp};
    assign go = state == S_IDLE && bus.op_valid;
    assign spm1 = AW'(sp_t - 1'b1);
    assign raddr = rd_local ? sum[AW-1:0] : spm1;
    always_comb begin
        state_t = state;
        sp_t = sp;
        fp_t = fp;
        we_t = 1'b0;
        rd_local = 1'b0;
        waddr = sp[AW-1:0];
        wdata = {tt_q, top_q};
        if (go) begin
            case (bus.op)
                OP_PUSH: begin
                    we_t = 1'b1;
                    wdata = {bus.type_in, bus.data_in};
                    sp_t = sp + 1'b1;
                end
                OP_POP: sp_t = sp - 1'b1;
                OP_GET_LOCAL, OP_SET_LOCAL, OP_TEE_LOCAL: begin
                    rd_local = 1'b1;
                    state_t = S_ACCESS;
                end
                OP_SET_FRAME: fp_t = bus.index;
                OP_DROP_TO: sp_t = sum[PW-1:0];
                default: ;
            endcase
        end else if (state == S_ACCESS) begin
            state_t = S_IDLE;
            we_t = 1'b1;
            if (acc_op == OP_GET_LOCAL) begin
                wdata = {acc_tag, acc_data};
                sp_t = sp + 1'b1;
            end else begin
                waddr = acc_addr;
                sp_t = acc_op == OP_SET_LOCAL ? sp - 1'b1 : sp;
            end
        end
    end
    always_comb begin
        code = TRAP_NONE;
        if (state == S_ACCESS)
            code = acc_op == OP_GET_LOCAL && sp == FULL ? TRAP_STACK_OVERFLOW : TRAP_NONE;
        else if (go) begin
            case (bus.op)
                OP_PUSH: code = USE_64B == 0 && bus.type_in[0] ? TRAP_NO_64B :
                                sp == FULL ? TRAP_STACK_OVERFLOW : TRAP_NONE;
                OP_POP: code = sp == fp ? TRAP_STACK_UNDERFLOW : TRAP_NONE;
                OP_GET_LOCAL: code = local_bad ? TRAP_LOCAL_RANGE : TRAP_NONE;
                OP_SET_LOCAL, OP_TEE_LOCAL: code = sp == fp ? TRAP_STACK_UNDERFLOW :
                                                   local_bad ? TRAP_LOCAL_RANGE :
                                                   rdata[DW+1:DW] != tt_q ? TRAP_TYPE_MISMATCH : TRAP_NONE;
                OP_SET_FRAME: code = bus.index > sp ? TRAP_STACK_UNDERFLOW : TRAP_NONE;
                OP_DROP_TO: code = sum > {1'b0, sp} ? TRAP_STACK_UNDERFLOW : TRAP_NONE;
                default: ;
            endcase
        end
    end
    assign halt = code != TRAP_NONE;
    assign state_n = halt ? S_HALT : state_t;
    assign sp_n = halt ? sp : sp_t;
    assign fp_n = halt ? fp : fp_t;
    // A write landing on the new top slot is forwarded instead of re-read.
    assign fwd = we_t && waddr == spm1;
    wasm_operand_stack_stack_ram #(.W(DW + 2), .AW(AW)) ram (
        .clk(clk),
        .we(we_t && !halt),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            sp <= '0;
            fp <= '0;
            trap <= TRAP_NONE;
            top_q <= '0;
            tt_q <= T_I32;
            acc_op <= OP_NOP;
            acc_addr <= '0;
            acc_data <= '0;
            acc_tag <= T_I32;
        end else begin
            state <= state_n;
            sp <= sp_n;
            fp <= fp_n;
            if (halt) trap <= code;
            if (rd_local) begin
                acc_op <= bus.op;
                acc_addr <= sum[AW-1:0];
                acc_data <= rdata[DW-1:0];
                acc_tag <= rdata[DW+1:DW];
            end else if (!halt && (go || state == S_ACCESS))
                {tt_q, top_q} <= sp_t == fp_t ? '0 : fwd ? wdata : rdata;
        end
    end
    assign bus.op_ready = state == S_IDLE;
    assign bus.top = top_q;
    assign bus.top_type = tt_q;
    assign bus.empty = sp == fp;
    assign bus.depth = sp - fp;
    assign bus.trap = trap;
endmodule

// File: tb/tb_wasm_operand_stack.sv
// tb_wasm_operand_stack: directed and random ops against an array-based stack model
module tb_wasm_operand_stack;
    import wasm_operand_stack_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [63:0] mem_m [128];
    logic [1:0] tag_m [128];
    int sp_m, fp_m, trap_m;

    wasm_operand_stack_if #(.DW(64), .PW(8)) b ();
    wasm_operand_stack_if #(.DW(32), .PW(8)) b32 ();

    wasm_operand_stack #(.USE_64B(1), .STACK_DEPTH(7)) dut (.clk(clk), .reset(reset), .bus(b));
    wasm_operand_stack #(.USE_64B(0), .STACK_DEPTH(7)) dut32 (.clk(clk), .reset(reset), .bus(b32));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $error("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string s, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", s, got, exp);
        end
    endtask

    task automatic check_all(input string s);
        logic [63:0] et;
        logic [1:0] ett;
        et = 64'd0;
        ett = 2'd0;
        if (sp_m != fp_m) begin
            et = mem_m[sp_m-1];
            ett = tag_m[sp_m-1];
        end
        chk({s, ":top"}, b.top, et);
        chk({s, ":top_type"}, 64'(b.top_type), 64'(ett));
        chk({s, ":depth"}, 64'(b.depth), 64'(sp_m - fp_m));
        chk({s, ":empty"}, 64'(b.empty), 64'(sp_m == fp_m));
        chk({s, ":trap"}, 64'(b.trap), 64'(trap_m));
        chk({s, ":op_ready"}, 64'(b.op_ready), 64'(trap_m == 0));
    endtask

    task automatic model(input logic [2:0] o, input logic [63:0] d, input logic [1:0] t, input int ix, output int cyc);
        int l;
        l = fp_m + ix;
        cyc = 1;
        if (trap_m != 0) return;
        case (o)
            OP_PUSH:
                if (sp_m == 128) trap_m = 1;
                else begin mem_m[sp_m] = d; tag_m[sp_m] = t; sp_m++; end
            OP_POP:
                if (sp_m == fp_m) trap_m = 2; else sp_m--;
            OP_GET_LOCAL:
                if (l >= sp_m) trap_m = 3;
                else begin
                    cyc = 2;
                    if (sp_m == 128) trap_m = 1;
                    else begin mem_m[sp_m] = mem_m[l]; tag_m[sp_m] = tag_m[l]; sp_m++; end
                end
            OP_SET_LOCAL, OP_TEE_LOCAL:
                if (sp_m == fp_m) trap_m = 2;
                else if (l >= sp_m) trap_m = 3;
                else if (tag_m[l] != tag_m[sp_m-1]) trap_m = 4;
                else begin
                    cyc = 2;
                    mem_m[l] = mem_m[sp_m-1];
                    tag_m[l] = tag_m[sp_m-1];
                    if (o == OP_SET_LOCAL) sp_m--;
                end
            OP_SET_FRAME:
                if (ix > sp_m) trap_m = 2; else fp_m = ix;
            OP_DROP_TO:
                if (l > sp_m) trap_m = 2; else sp_m = l;
            default: ;
        endcase
    endtask

    task automatic step(input logic [2:0] o, input logic [63:0] d, input logic [1:0] t, input logic [7:0] ix, input string s);
        int cyc;
        model(o, d, t, int'(ix), cyc);
        @(negedge clk);
        b.op = o;
        b.op_valid = 1'b1;
        b.data_in = d;
        b.type_in = t;
        b.index = ix;
        @(posedge clk);
        #1;
        b.op_valid = 1'b0;
        if (cyc == 2) begin
            chk({s, ":ready_access"}, 64'(b.op_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        check_all(s);
    endtask

    task automatic step32(input logic [2:0] o, input logic [31:0] d, input logic [1:0] t);
        @(negedge clk);
        b32.op = o;
        b32.op_valid = 1'b1;
        b32.data_in = d;
        b32.type_in = t;
        b32.index = 8'd0;
        @(posedge clk);
        #1;
        b32.op_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        b.op_valid = 1'b0;
        b32.op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        sp_m = 0;
        fp_m = 0;
        trap_m = 0;
    endtask

    initial begin
        logic [2:0] o;
        logic [1:0] t;
        logic [63:0] last;
        int r;
        b.op = OP_NOP; b.op_valid = 1'b0; b.data_in = '0; b.type_in = '0; b.index = '0;
        b32.op = OP_NOP; b32.op_valid = 1'b0; b32.data_in = '0; b32.type_in = '0; b32.index = '0;
        do_reset();
        check_all("reset");

        step(OP_PUSH, 64'd1, T_I64, 8'd0, "push1");
        step(OP_PUSH, 64'd2, T_I64, 8'd0, "push2");
        chk("tp1:depth", 64'(b.depth), 64'd2);
        chk("tp1:top", b.top, 64'd2);
        chk("tp1:top_type", 64'(b.top_type), 64'(T_I64));

        do_reset();
        step(OP_SET_FRAME, 64'd0, T_I32, 8'd0, "frame0");
        step(OP_PUSH, 64'd5, T_I64, 8'd0, "push5");
        step(OP_PUSH, 64'd2, T_I64, 8'd0, "push2b");
        step(OP_TEE_LOCAL, 64'd0, T_I32, 8'd0, "tee0");
        chk("tee:depth", 64'(b.depth), 64'd2);
        chk("tee:top", b.top, 64'd2);
        step(OP_POP, 64'd0, T_I32, 8'd0, "pop");
        step(OP_GET_LOCAL, 64'd0, T_I32, 8'd0, "get0");
        chk("get:top", b.top, 64'd2);

        do_reset();
        step(OP_PUSH, 64'h55, T_I32, 8'd0, "mm_push_i32");
        step(OP_PUSH, 64'h3f800000, T_F32, 8'd0, "mm_push_f32");
        step(OP_SET_LOCAL, 64'd0, T_I32, 8'd0, "mm_set");
        chk("mismatch:trap", 64'(b.trap), 64'(TRAP_TYPE_MISMATCH));

        do_reset();
        last = '0;
        for (int i = 0; i < 128; i++) begin
            last = {$urandom, $urandom};
            step(OP_PUSH, last, 2'($urandom_range(0, 3)), 8'd0, "fill");
        end
        step(OP_PUSH, 64'hdead, T_I32, 8'd0, "overflow");
        chk("ovf:trap", 64'(b.trap), 64'(TRAP_STACK_OVERFLOW));
        chk("ovf:depth", 64'(b.depth), 64'd128);
        chk("ovf:top", b.top, last);

        do_reset();
        step(OP_PUSH, 64'd3, T_I32, 8'd0, "ma_push");
        @(negedge clk);
        b.op = OP_GET_LOCAL;
        b.index = 8'd0;
        b.op_valid = 1'b1;
        @(posedge clk);
        #1;
        b.op_valid = 1'b0;
        chk("ma:ready_access", 64'(b.op_ready), 64'd0);
        reset = 1'b1;
        #1;
        sp_m = 0;
        fp_m = 0;
        trap_m = 0;
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        step(OP_PUSH, 64'd7, T_I32, 8'd0, "after_reset");
        chk("ar:top", b.top, 64'd7);
        chk("ar:depth", 64'(b.depth), 64'd1);

        do_reset();
        step32(OP_PUSH, 32'h11, T_I32);
        chk("n64:top", 64'(b32.top), 64'h11);
        chk("n64:depth", 64'(b32.depth), 64'd1);
        step32(OP_PUSH, 32'h22, T_I64);
        chk("n64:trap", 64'(b32.trap), 64'(TRAP_NO_64B));
        chk("n64:op_ready", 64'(b32.op_ready), 64'd0);
        chk("n64:depth_kept", 64'(b32.depth), 64'd1);
        step32(OP_PUSH, 32'h33, T_I32);
        chk("n64:ignored_depth", 64'(b32.depth), 64'd1);
        chk("n64:ignored_top", 64'(b32.top), 64'h11);
        chk("n64:trap_sticky", 64'(b32.trap), 64'(TRAP_NO_64B));

        for (int e = 0; e < 30; e++) begin
            do_reset();
            check_all("rnd_reset");
            for (int k = 0; k < 40 && trap_m == 0; k++) begin
                r = $urandom_range(0, 99);
                o = r < 40 ? OP_PUSH : r < 52 ? OP_POP : r < 64 ? OP_GET_LOCAL :
                    r < 74 ? OP_SET_LOCAL : r < 84 ? OP_TEE_LOCAL : r < 89 ? OP_SET_FRAME :
                    r < 95 ? OP_DROP_TO : OP_NOP;
                t = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
                step(o, {$urandom, $urandom}, t, 8'($urandom_range(0, 5)), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wasm_operand_stack.md
Name: wasm_operand_stack

Overview:
- Parametrised typed operand stack for the wasm CPU core, with frame-relative local-variable access (get_local / set_local / tee_local).
- Replaces the fixed-width stack inside cpu. Width, depth and 64-bit support are parameters.
- Enforces type-tag, overflow/underflow and 64-bit-capability rules; reports them as sticky trap codes.
- Sits between the cpu decode stage and the ALU/FPU operand path.

Parameters:
- USE_64B, 1, 1: entries are 64 bits and i64/f64 are legal. 0: entries are 32 bits and i64/f64 pushes trap NO_64B.
- STACK_DEPTH, 7, stack holds 2**STACK_DEPTH entries; pointers are STACK_DEPTH+1 bits wide.
- DW, derived, 64 if USE_64B else 32.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- op  in  3  NOP=0, PUSH=1, POP=2, GET_LOCAL=3, SET_LOCAL=4, TEE_LOCAL=5, SET_FRAME=6, DROP_TO=7
- op_valid  in  1  op request qualifier
- op_ready  out  1  block can accept an op this cycle
- data_in  in  DW  PUSH value
- type_in  in  2  PUSH type tag: i32=0, i64=1, f32=2, f64=3
- index  in  STACK_DEPTH+1  local index (GET/SET/TEE), new frame base (SET_FRAME), or target depth (DROP_TO)
- top  out  DW  current top-of-stack value
- top_type  out  2  tag of top
- empty  out  1  stack pointer == frame base
- depth  out  STACK_DEPTH+1  entries above frame base
- trap  out  4  sticky trap code: NONE=0, STACK_OVERFLOW, STACK_UNDERFLOW, LOCAL_RANGE, TYPE_MISMATCH, NO_64B

Behaviour:
- Reset (asynchronous): sp=0, fp=0, trap=NONE, op_ready=1, top=0, top_type=i32, empty=1, depth=0. Stack RAM contents are undefined.
- Handshake: an op is accepted on a rising clk edge when op_valid&&op_ready. After any trap is set, op_ready=0 until reset.
- PUSH: 1 cycle. mem[sp]<=data_in, tag[sp]<=type_in, sp++. If sp==2**STACK_DEPTH, the push is blocked and trap=STACK_OVERFLOW. If !USE_64B and type_in is i64/f64, the push is blocked and trap=NO_64B; this check takes priority over overflow.
- POP: 1 cycle, sp--. If sp==fp, trap=STACK_UNDERFLOW and state is unchanged.
- GET_LOCAL: 2 cycles; op_ready=0 in cycle 2.
  - Cycle 1: read mem[fp+index].
  - Cycle 2: push the read value with its tag. Overflow rules as PUSH.
  - fp+index>=sp gives trap=LOCAL_RANGE.
- SET_LOCAL: 2 cycles; op_ready=0 in cycle 2.
  - Cycle 1: compare top_type with tag[fp+index]. A mismatch gives trap=TYPE_MISMATCH.
  - Cycle 2: write top into the local, then sp--.
  - Empty stack gives STACK_UNDERFLOW.
  - If the local slot is the top entry itself (index==depth-1), the net effect is a pop only.
- TEE_LOCAL: same as SET_LOCAL, but sp is unchanged and top stays valid.
- SET_FRAME: 1 cycle. fp<=index. index>sp gives trap=STACK_UNDERFLOW.
- DROP_TO: 1 cycle. sp<=fp+index. fp+index>sp gives trap=STACK_UNDERFLOW.
- State machine:
  - IDLE --(GET/SET/TEE accepted)--> ACCESS --> IDLE.
  - Any state --(trap)--> HALT.
  - HALT exits only on reset.
- Outputs:
  - top/top_type are registered and reflect mem[sp-1] the cycle after any op completes. A forwarding register avoids a RAM read-after-write bubble.
  - On an empty stack, top=0 and top_type=i32.
- Arithmetic: all pointer sums are STACK_DEPTH+1 bits with no wrap. A carry out of fp+index is treated as LOCAL_RANGE or STACK_UNDERFLOW, according to the op.
- Simultaneous events: at most one op per cycle. If the first trap and an op validate on the same edge, the op has no side effects.
- Reset mid-ACCESS: abandons the op and clears all state. A partial local write must not be visible afterward, since sp=fp=0.
- When !USE_64B, the upper 32 bits of top read 0 when observed through a 64-bit bus.

Decomposition:
- Shared package / cpu.vh: type tag constants (i32, i64, f32, f64), trap codes, and op encodings. The trap codes must match the existing cpu trap enumeration, including NO_64B.
- One sub-module, stack_ram: a dual-port (1R1W) register array DW+2 bits wide, with 2**STACK_DEPTH entries and a synchronous write.

Test Plan:
- Reset, then PUSH i64 1 and PUSH i64 2 → depth=2, top=2, top_type=i64, empty=0, trap=NONE.
- SET_FRAME 0; PUSH i64 5; PUSH i64 2; TEE_LOCAL 0 → depth=2, top=2, top_type=i64; after POP then GET_LOCAL 0 → top=2 (the tee_local result).
- USE_64B=0: PUSH type i64 → trap=NO_64B the next cycle, op_ready=0, depth unchanged; a subsequent PUSH i32 is ignored.
- Fill 2**STACK_DEPTH entries (128 pushes), then push once more → trap=STACK_OVERFLOW, depth=128, top equals the last value pushed.
- PUSH f32 0x3f800000; SET_LOCAL 0 where local 0 is i32 → trap=TYPE_MISMATCH and the local is unchanged.
- Assert reset during the ACCESS cycle of GET_LOCAL → all outputs return to reset values immediately (asynchronously); the next PUSH i32 7 gives top=7, depth=1.
